// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode enum, flag struct and opcode width for the pipelined ALU.
package alu_pkg;
    localparam int OPC_W = 3;
    typedef enum logic [OPC_W-1:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_ADDS
    } alu_op_e;
    typedef struct packed {
        logic err;
        logic v;
        logic n;
        logic z;
        logic c;
    } alu_flags_t;
endpackage

// File: rtl/alu_core.sv
// alu_core: combinational ALU datapath with status flags.
// Opcode 7 is a saturating add when ALU_PIPE_SAT_EN is defined, otherwise an illegal op.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  alu_op_e          op,
    output logic [WIDTH-1:0] result,
    output alu_flags_t       flags
);
    localparam int SW = $clog2(WIDTH);
    localparam int M  = WIDTH - 1;
    logic [SW-1:0]    sh;
    logic [WIDTH:0]   sum, diff, shl_w, shr_w;
    logic [WIDTH-1:0] res;
    logic             c, v, err;
    // The extra bit of each shift window captures the last bit shifted out.
    always_comb begin
        sh    = b[SW-1:0];
        sum   = {1'b0, a} + {1'b0, b};
        diff  = {1'b0, a} - {1'b0, b};
        shl_w = {1'b0, a} << sh;
        shr_w = {a, 1'b0} >> sh;
        res   = '0;
        c     = 1'b0;
        v     = 1'b0;
        err   = 1'b0;
        case (op)
            OP_ADD: begin
                res = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (a[M] == b[M]) && (sum[M] != a[M]);
            end
            OP_SUB: begin
                res = diff[WIDTH-1:0];
                c   = diff[WIDTH];
                v   = (a[M] != b[M]) && (diff[M] != a[M]);
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_SHL: begin
                res = shl_w[WIDTH-1:0];
                c   = shl_w[WIDTH];
            end
            OP_SHR: begin
                res = shr_w[WIDTH:1];
                c   = shr_w[0];
            end
            default: begin
`ifdef ALU_PIPE_SAT_EN
                res = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
                c   = sum[WIDTH];
`else
                err = 1'b1;
`endif
            end
        endcase
        result = res;
        flags  = '{err: err, v: v, n: res[M], z: (res == '0), c: c};
    end
endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: 2-stage valid/ready pipelined ALU with an output-handshake counter.
// Optional saturating add on opcode 7 is enabled by ALU_PIPE_SAT_EN (see alu_core).
module alu_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OPC_W-1:0] opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output alu_flags_t       flags,
    output logic [CNT_W-1:0] op_count
);
    logic             s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d, s1_b_q, s1_b_d;
    alu_op_e          s1_op_q, s1_op_d;
    logic [WIDTH-1:0] s2_res_q, s2_res_d, core_res;
    alu_flags_t       s2_flags_q, s2_flags_d, core_flags;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s1_adv, s2_adv;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a      (s1_a_q),
        .b      (s1_b_q),
        .op     (s1_op_q),
        .result (core_res),
        .flags  (core_flags)
    );

    // Each stage only loads when the one downstream frees up, so a stalled sink holds everything.
    always_comb begin
        s2_adv     = !s2_valid_q || out_ready;
        s1_adv     = !s1_valid_q || s2_adv;
        s1_valid_d = s1_adv ? in_valid : s1_valid_q;
        s1_a_d     = (s1_adv && in_valid) ? a : s1_a_q;
        s1_b_d     = (s1_adv && in_valid) ? b : s1_b_q;
        s1_op_d    = (s1_adv && in_valid) ? alu_op_e'(opcode) : s1_op_q;
        s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
        s2_res_d   = (s2_adv && s1_valid_q) ? core_res : s2_res_q;
        s2_flags_d = (s2_adv && s1_valid_q) ? core_flags : s2_flags_q;
        cnt_d      = cnt_q + CNT_W'(s2_valid_q && out_ready);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= OP_ADD;
            s2_valid_q <= 1'b0;
            s2_res_q   <= '0;
            s2_flags_q <= '0;
            cnt_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_op_q    <= s1_op_d;
            s2_valid_q <= s2_valid_d;
            s2_res_q   <= s2_res_d;
            s2_flags_q <= s2_flags_d;
            cnt_q      <= cnt_d;
        end
    end

    assign in_ready  = s1_adv;
    assign out_valid = s2_valid_q;
    assign result    = s2_res_q;
    assign flags     = s2_flags_q;
    assign op_count  = cnt_q;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and randomised-stall checks of alu_pipe at WIDTH=8.
module tb_alu_pipe;
    import alu_pkg::*;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  a = '0;
    logic [7:0]  b = '0;
    logic [2:0]  opcode = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [7:0]  result;
    alu_flags_t  flags;
    logic [15:0] op_count;
    int          n_run = 0;
    int          n_fail = 0;
    int          delivered = 0;
    logic [7:0]  va [1000];
    logic [7:0]  vb [1000];
    logic [2:0]  vop [1000];
    logic [12:0] expq [$];

    alu_pipe #(.WIDTH(8), .CNT_W(16)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .op_count  (op_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Independent integer reference; returns {err,v,n,z,c,result}.
    function automatic logic [12:0] model(input logic [7:0] x, input logic [7:0] y, input logic [2:0] o);
        int ua = int'(x);
        int ub = int'(y);
        int sa = int'($signed(x));
        int sb = int'($signed(y));
        int sh = int'(y) % 8;
        int r = 0;
        int s = 0;
        logic c = 1'b0;
        logic v = 1'b0;
        logic e = 1'b0;
        logic [7:0] rr;
        case (o)
            3'd0: begin r = ua + ub; c = r > 255; s = sa + sb; v = s > 127 || s < -128; end
            3'd1: begin r = ua - ub; c = ua < ub; s = sa - sb; v = s > 127 || s < -128; end
            3'd2: r = ua & ub;
            3'd3: r = ua | ub;
            3'd4: r = ua ^ ub;
            3'd5: begin r = ua << sh; c = ((r >> 8) & 1) != 0; end
            3'd6: begin r = ua >> sh; c = sh != 0 && ((ua >> (sh - 1)) & 1) != 0; end
            default: begin
`ifdef ALU_PIPE_SAT_EN
                r = ua + ub;
                c = r > 255;
                if (c) r = 255;
`else
                e = 1'b1;
`endif
            end
        endcase
        rr = r[7:0];
        return {e, v, rr[7], rr == 8'd0, c, rr};
    endfunction

    task automatic run1(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                        input logic [2:0] iop, input logic [12:0] exp);
        a = ia;
        b = ib;
        opcode = iop;
        in_valid = 1'b1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check({tag, "_early"}, 32'(out_valid), 32'd0);
        tick();
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check(tag, 32'({flags, result}), 32'(exp));
        tick();
        delivered++;
    endtask

    task automatic stream(input int n, input bit rnd);
        int sent = 0;
        int got = 0;
        int cyc = 0;
        bit acc, del;
        logic [12:0] e;
        while (got < n && cyc < n * 10 + 50) begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : (cyc >= 8);
            in_valid = (sent < n) && (!rnd || $urandom_range(0, 3) != 0);
            if (sent < n) begin
                a = va[sent];
                b = vb[sent];
                opcode = vop[sent];
            end
            #1;
            acc = in_valid && in_ready;
            del = out_valid && out_ready;
            if (!rnd && cyc == 3) begin
                check("stall_in_ready", 32'(in_ready), 32'd0);
                check("stall_accepts", 32'(sent), 32'd2);
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_res", 32'(result), 32'h11);
            end
            if (!rnd && cyc == 7)
                check("stall_hold", 32'(result), 32'h11);
            if (del) begin
                e = (expq.size() > 0) ? expq.pop_front() : 13'h1fff;
                check("stream_out", 32'({flags, result}), 32'(e));
                got++;
                delivered++;
            end
            if (acc) begin
                expq.push_back(model(a, b, opcode));
                sent++;
            end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        check("stream_count", 32'(got), 32'(n));
        check("stream_drained", 32'(expq.size()), 32'd0);
    endtask

    initial begin
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out", 32'({flags, result}), 32'd0);
        check("rst_count", 32'(op_count), 32'd0);
        reset = 1'b0;
        tick();
        run1("add_wrap", 8'hFF, 8'h01, 3'd0, {5'b00011, 8'h00});
        check("count_1", 32'(op_count), 32'd1);
        run1("sub_borrow", 8'h05, 8'h07, 3'd1, {5'b00101, 8'hFE});
        run1("add_ovf", 8'h7F, 8'h01, 3'd0, {5'b01100, 8'h80});
        run1("shl_1", 8'h81, 8'h01, 3'd5, {5'b00001, 8'h02});
        run1("shl_0", 8'h81, 8'h08, 3'd5, {5'b00100, 8'h81});
        run1("shr_3", 8'h81, 8'h03, 3'd6, {5'b00000, 8'h10});
        run1("shr_1", 8'h85, 8'h01, 3'd6, {5'b00001, 8'h42});
        run1("and", 8'hF0, 8'h3C, 3'd2, {5'b00000, 8'h30});
        run1("or", 8'h0F, 8'hF0, 3'd3, {5'b00100, 8'hFF});
        run1("xor_zero", 8'hAA, 8'hAA, 3'd4, {5'b00010, 8'h00});
`ifdef ALU_PIPE_SAT_EN
        run1("adds", 8'hF0, 8'h20, 3'd7, {5'b00101, 8'hFF});
`else
        run1("op7_illegal", 8'hF0, 8'h20, 3'd7, {5'b10010, 8'h00});
`endif
        check("count_dir", 32'(op_count), 32'(delivered));
        for (int k = 0; k < 6; k++) begin
            va[k] = 8'(k + 1);
            vb[k] = 8'h10;
            vop[k] = 3'd0;
        end
        stream(6, 1'b0);
        check("count_stall", 32'(op_count), 32'(delivered));
        out_ready = 1'b0;
        a = 8'h11;
        b = 8'h22;
        opcode = 3'd0;
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_res", 32'(result), 32'd0);
        check("arst_count", 32'(op_count), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        tick();
        #2;
        reset = 1'b0;
        delivered = 0;
        tick();
        run1("post_rst_add", 8'h03, 8'h04, 3'd0, {5'b00000, 8'h07});
        check("post_rst_count", 32'(op_count), 32'd1);
        for (int k = 0; k < 1000; k++) begin
            va[k] = 8'($urandom);
            vb[k] = 8'($urandom);
            vop[k] = 3'($urandom);
        end
        stream(1000, 1'b1);
        out_ready = 1'b1;
        tick();
        check("count_final", 32'(op_count), 32'd1001);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
